// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the memory command struct, the bus geometry and the arbiter state enum.
package mem_port_arbiter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BANDWIDTH  = 4;
    localparam int ADDR_WIDTH = 11;
    localparam int WORD_WIDTH = BANDWIDTH * DATA_WIDTH;

    // One memory command as issued by a requester or presented on the shared port.
    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ADDR_WIDTH-1:0] address;
        logic [WORD_WIDTH-1:0] writedata;
    } mem_t;

    // IDLE: nobody owns the port.  OWNED: exactly one grant bit is set.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Width of a requester index; never zero so a single requester still works.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A simultaneous read+write is treated as a write only: the read is dropped
    // so no read data is ever expected for that cycle.
    function automatic mem_t drop_colliding_read(input mem_t cmd);
        mem_t c;
        c = cmd;
        if (c.read && c.write) begin
            c.read = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the arbiter.
// slave modport: the arbiter.  master modport: requesters plus memory model.
// Handshake: a requester holds req (and lock for a burst) until it sees its
// gnt bit; each cycle with gnt and req both high is one transfer.  Read data
// is flagged by rvalid one cycle after the read transfer.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    lock;
    mem_t [NUM_REQ-1:0]    req_mem;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    mem_t                  port_mem;
    logic [WORD_WIDTH-1:0] port_readdata;
    logic [WORD_WIDTH-1:0] readdata;
    logic                  busy;
    logic                  timeout;
    arb_state_t            state;     // debug view of the arbiter FSM

    modport slave (
        input  req, lock, req_mem, port_readdata,
        output gnt, rvalid, port_mem, readdata, busy, timeout, state
    );

    modport master (
        output req, lock, req_mem, port_readdata,
        input  gnt, rvalid, port_mem, readdata, busy, timeout, state
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or above ptr, with wrap-around.
// Requesters set in exclude are skipped (used to pass over the releasing owner).
module rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int PW     = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [NUM_REQ-1:0] eligible;
    logic [PW:0]        sum;
    logic [PW-1:0]      idx;

    // Walk the requesters starting at ptr and take the first eligible one.
    always_comb begin
        eligible = req & ~exclude;
        pick     = '0;
        valid    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            idx = sum[PW-1:0];
            if (!valid && eligible[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Grants are registered (one cycle latency), a requester may hold the port
// across a burst with lock, and read data validity follows the issuing
// requester one cycle after the read.
// Optional feature: define ARB_TIMEOUT_EN to force-release a lock held for
// MAX_HOLD cycles, pulsing timeout for one cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int PW = ptr_width(NUM_REQ);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("mem_port_arbiter: MAX_HOLD must be at least 1");
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               timeout_q, timeout_d;

    logic [PW-1:0]      owner_idx;
    logic [PW-1:0]      next_ptr;
    logic               owner_req;
    logic               owner_lock;
    mem_t               owner_cmd;
    mem_t               port_cmd;
    logic               transfer;
    logic               release_gnt;
    logic               hold_expired;

    logic [PW-1:0]      pick_ptr;
    logic [NUM_REQ-1:0] pick_excl;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;

    // Decode the current owner: its index, request, lock and command.
    always_comb begin
        owner_idx  = '0;
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        owner_cmd  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                owner_idx  = PW'(i);
                owner_req  = bus.req[i];
                owner_lock = bus.lock[i];
                owner_cmd  = bus.req_mem[i];
            end
        end
    end

    assign next_ptr = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);

    // Only the owner's command reaches the port, and only while it requests.
    assign transfer = (state_q == OWNED) && owner_req;
    assign port_cmd = transfer ? drop_colliding_read(owner_cmd) : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    assign hold_expired = transfer && owner_lock && (hold_cnt_q == HW'(MAX_HOLD - 1));

    // Count locked owner cycles; any release or idle period clears the count.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if ((state_q == IDLE) || release_gnt) begin
            hold_cnt_d = '0;
        end else if (owner_lock) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // The grant is given up on a non-locked transfer, a dropped request or a lock timeout.
    assign release_gnt = (state_q == OWNED) && (!owner_req || !owner_lock || hold_expired);

    // On release the search restarts just above the owner and skips it.
    assign pick_ptr  = (state_q == OWNED) ? next_ptr : rr_ptr_q;
    assign pick_excl = (state_q == OWNED) ? gnt_q : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .pick    (pick),
        .valid   (pick_valid)
    );

    // Next-state logic: grant, pointer, read tracking and timeout pulse.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = 1'b0;
        rvalid_d  = port_cmd.read ? gnt_q : '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWNED;
                    gnt_d   = pick;
                end
            end
            OWNED: begin
                if (release_gnt) begin
                    rr_ptr_d  = next_ptr;
                    timeout_d = hold_expired;
                    if (pick_valid) begin
                        gnt_d = pick;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers; reset drops any transfer in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rr_ptr_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rr_ptr_q  <= rr_ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.port_mem = port_cmd;
    assign bus.readdata = bus.port_readdata;
    assign bus.busy     = |gnt_q;
    assign bus.timeout  = timeout_q;
    assign bus.state    = state_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters sharing one memory port.
REQ-002 SHALL have parameter MAX_HOLD, default 256, lock-hold cycle limit (used only under ARB_TIMEOUT_EN).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester access request.
REQ-006 SHALL have port lock  in  NUM_REQ  per-requester hold-grant across consecutive transfers (burst).
REQ-007 SHALL have port req_mem  in  NUM_REQ x mem_t  per-requester read/write/address/writedata.
REQ-008 SHALL have port gnt  out  NUM_REQ  one-hot registered grant.
REQ-009 SHALL have port rvalid  out  NUM_REQ  readdata valid for that requester.
REQ-010 SHALL have port port_mem  out  mem_t  shared memory port command.
REQ-011 SHALL have port port_readdata  in  BANDWIDTH*DATA_WIDTH  shared memory read data.
REQ-012 SHALL have port readdata  out  BANDWIDTH*DATA_WIDTH  port_readdata broadcast to all requesters.
REQ-013 SHALL have port busy  out  1  high while any grant is held.
REQ-014 SHALL have port timeout  out  1  one-cycle forced-release pulse.

Function
REQ-015 SHALL implement two states, IDLE (no owner) and OWNED (gnt has exactly one bit set).
REQ-016 IDLE->OWNED SHALL occur when any req is high; the owner is the first requester with req high, searching upward with wrap-around from rr_ptr; gnt rises the next cycle (1-cycle grant latency).
REQ-017 In OWNED, port_mem SHALL equal req_mem[owner] combinationally while req[owner] is high; otherwise port_mem SHALL be all zero.
REQ-018 A non-owner's req_mem SHALL never reach port_mem.
REQ-019 A transfer cycle is OWNED with req[owner]=1; if lock[owner]=0, the arbiter SHALL re-arbitrate in that same cycle with the owner excluded, so the next owner's gnt appears the following cycle with no bubble, or the state returns to IDLE if no other req is high.
REQ-020 With lock[owner]=1, the grant SHALL be held regardless of other requests.
REQ-021 If req[owner] drops in OWNED, the arbiter SHALL release the grant and re-arbitrate as in REQ-019.
REQ-022 On every grant release, rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-023 rvalid[owner] SHALL assert exactly one cycle after a cycle in which port_mem.read=1 (1-cycle memory latency), and SHALL track the issuing requester even if the grant has moved.
REQ-024 If read and write are both high, the write SHALL be forwarded, the read forced low, and no rvalid generated.
REQ-025 busy SHALL equal OR of gnt.

Reset
REQ-026 Asserting reset_n low SHALL asynchronously clear gnt, rvalid, timeout, busy, the hold counter and rr_ptr to 0 and force IDLE; port_mem SHALL read zero.
REQ-027 Reset mid-burst SHALL drop the transfer with no rvalid afterwards; arbitration SHALL resume on the first clock edge after reset_n goes high.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined, a hold counter SHALL count OWNED cycles with lock[owner]=1; on reaching MAX_HOLD the grant SHALL be force-released, timeout SHALL pulse for one cycle, and the counter SHALL clear on any release.
REQ-029 Without ARB_TIMEOUT_EN, no hold counter SHALL exist, timeout SHALL be tied 0, and lock SHALL hold the grant indefinitely.

Structure
REQ-030 The mem_t struct, BANDWIDTH, DATA_WIDTH and ADDR_WIDTH SHALL come from the shared macro/package header; the arb_state_t enum (IDLE, OWNED) SHALL be added to the shared package.
REQ-031 The round-robin search SHALL live in one sub-module, rr_pick (inputs: request vector, pointer, exclude mask; output: one-hot pick plus valid).

Verification
REQ-032 Bench SHALL drive req=3'b111, lock=0 continuously -> gnt sequence 001,010,100,001 with no idle cycle between grants.
REQ-033 Bench SHALL drive req[1] read at address 11'h010 -> gnt[1] the next cycle, port_mem.address=11'h010, rvalid[1] one cycle after the read, readdata equal to port_readdata.
REQ-034 Bench SHALL have req[0] with lock=1 for 4 cycles while req[2] is high -> gnt[0] held 4 cycles, then gnt[2].
REQ-035 Bench SHALL assert read and write together from requester 2 -> port_mem.write=1, port_mem.read=0, rvalid[2] never asserted.
REQ-036 Bench SHALL pull reset_n low during a 4-beat locked burst -> gnt, rvalid and busy 0 immediately; after release with req=3'b100, the first grant is gnt[2].
REQ-037 Bench SHALL run with ARB_TIMEOUT_EN defined and MAX_HOLD=8, holding lock[1]=1 -> forced release after 8 cycles, timeout high exactly 1 cycle, next waiting requester granted.
